// File: rtl/port_fifo_responder_if.sv
// CPU-strobe and device valid/ready signal bundle for one decoded port line.
// The slave modport belongs to the responder; the master modport to the CPU/device side.
interface port_fifo_responder_if;
  logic       _sel_wr;
  logic       _sel_rd;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       overflow;

  modport slave (
    input  _sel_wr, _sel_rd, data_in, tx_ready, rx_data, rx_valid,
    output data_out, data_oe, tx_data, tx_valid, rx_ready, overflow
  );

  modport master (
    output _sel_wr, _sel_rd, data_in, tx_ready, rx_data, rx_valid,
    input  data_out, data_oe, tx_data, tx_valid, rx_ready, overflow
  );
endinterface

// File: rtl/port_fifo_responder.sv
// Port endpoint: CPU write strobes fill a TX FIFO, device fills an RX FIFO read by CPU strobes.
// Latency: push visible after the capturing edge; data_out/tx_data combinational from FIFO heads.
// Backpressure: rx_ready low when RX full; CPU writes to a full TX are dropped (sticky flag if PORT_FIFO_RESPONDER_OVERFLOW_EN).
module port_fifo_responder #(
  parameter int DEPTH = 4
) (
  input logic                   CLK,
  input logic                   MR,
  port_fifo_responder_if.slave  bus
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

  logic          prev_wr;
  logic          prev_rd;

  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] tx_rd_ptr;
  logic [AW-1:0] tx_wr_ptr;
  logic [AW:0]   tx_cnt;

  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] rx_rd_ptr;
  logic [AW-1:0] rx_wr_ptr;
  logic [AW:0]   rx_cnt;

  logic wr_evt, rd_evt;
  logic tx_full, tx_empty, tx_push, tx_pop;
  logic rx_full, rx_empty, rx_push, rx_pop;

  always_comb begin
    wr_evt   = prev_wr && !bus._sel_wr;
    rd_evt   = !prev_rd && bus._sel_rd;
    tx_full  = (tx_cnt == FULL_CNT);
    tx_empty = (tx_cnt == '0);
    rx_full  = (rx_cnt == FULL_CNT);
    rx_empty = (rx_cnt == '0);
    tx_pop   = !tx_empty && bus.tx_ready;
    // A full TX still takes the write when the device drains a slot on the same edge.
    tx_push  = wr_evt && (!tx_full || tx_pop);
    rx_push  = bus.rx_valid && !rx_full;
    rx_pop   = rd_evt && !rx_empty;
  end

  // Reset parks the strobe history at "idle" so a strobe spanning reset never fires.
  always_ff @(posedge CLK) begin
    if (MR) begin
      prev_wr <= 1'b0;
      prev_rd <= 1'b1;
    end else begin
      prev_wr <= bus._sel_wr;
      prev_rd <= bus._sel_rd;
    end
  end

  always_ff @(posedge CLK) begin
    if (MR) begin
      tx_rd_ptr <= '0;
      tx_wr_ptr <= '0;
      tx_cnt    <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + CNT_ONE;
        2'b01:   tx_cnt <= tx_cnt - CNT_ONE;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!MR && tx_push) tx_mem[tx_wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge CLK) begin
    if (MR) begin
      rx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_cnt    <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + CNT_ONE;
        2'b01:   rx_cnt <= rx_cnt - CNT_ONE;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!MR && rx_push) rx_mem[rx_wr_ptr] <= bus.rx_data;
  end

`ifdef PORT_FIFO_RESPONDER_OVERFLOW_EN
  logic overflow_q;

  always_ff @(posedge CLK) begin
    if (MR)
      overflow_q <= 1'b0;
    else if (wr_evt && !tx_push)
      overflow_q <= 1'b1;
  end

  assign bus.overflow = overflow_q;
`else
  assign bus.overflow = 1'b0;
`endif

  assign bus.tx_data  = tx_mem[tx_rd_ptr];
  assign bus.tx_valid = !tx_empty;
  assign bus.rx_ready = !rx_full;
  assign bus.data_out = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
  assign bus.data_oe  = !bus._sel_rd;

endmodule
